instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Fetch front-end feeding the 2-stage processor's instruction input channel.
- Generates word-aligned PCs and reads a synchronous instruction memory (1-cycle read latency).
- Buffers responses with their PCs in a small FIFO and presents {instr, pc} on a valid/ready channel.
- Supports redirect (branch/jump) with flush, and stops fetching at a programmable PC limit.

Parameters:
- ADDR_W, 32, PC / memory byte-address width.
- FIFO_DEPTH, 2, entries of {pc, instr}; legal range 2..8.
- RESET_PC, 0, first fetch address after reset (word-aligned).
- PC_LIMIT, 88, no fetch is issued for pc >= PC_LIMIT (unsigned compare).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_en_o  in/out: out  1  read request this cycle
- imem_addr_o  out  ADDR_W  byte address of the request; bits[1:0] always 0
- imem_rdata_i  in  32  instruction word, valid the cycle after imem_en_o=1
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  ADDR_W  new fetch PC; bits[1:0] are ignored and forced to 0
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  consumer accepts the head
- out_instr_o  out  32  head instruction; 0 when empty
- out_pc_o  out  ADDR_W  head PC; 0 when empty
- fetch_done_o  out  1  fetch reached PC_LIMIT and all fetched words have drained

Behaviour:
- Reset (sync, active-high):
  - fetch_pc = RESET_PC, FIFO empty, no request in flight, FSM = FETCH.
  - Outputs: imem_en_o=0, out_valid_o=0, out_instr_o=0, out_pc_o=0, fetch_done_o=0.
  - Reset mid-operation discards FIFO contents and any in-flight read; the response arriving the next cycle is not written.
- FSM:
  - FETCH -> DRAIN when fetch_pc >= PC_LIMIT.
  - DRAIN -> DONE when the FIFO is empty and nothing is in flight.
  - DONE holds until redirect or reset; fetch_done_o=1 only in DONE.
  - A redirect from any state goes to FETCH; the PC_LIMIT check is re-evaluated next cycle.
- Issue rule (combinational):
  - imem_en_o=1 iff state==FETCH, !reset, !redirect_i, fetch_pc < PC_LIMIT, and (count + inflight - pop) < FIFO_DEPTH, where pop = out_valid_o & out_ready_i.
  - imem_addr_o = fetch_pc. On issue, fetch_pc += 4 (mod 2^ADDR_W, wraps silently).
  - The issued PC is held in an in-flight register with inflight=1.
- Response: the cycle after an issue, {inflight_pc, imem_rdata_i} is pushed into the FIFO unless it was killed by redirect or reset. The credit rule guarantees a push never hits a full FIFO.
- Latency: an instruction issued in cycle N is visible on out_* in cycle N+2 (no bypass).
- Throughput: 1 instr/cycle sustained with out_ready_i=1.
- Handshake:
  - Transfer occurs when out_valid_o & out_ready_i.
  - out_* stay stable while valid && !ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect:
  - A handshake in the redirect cycle still completes, and the consumer keeps that word.
  - Then the FIFO is cleared and the in-flight response is dropped.
  - fetch_pc = {redirect_pc_i[ADDR_W-1:2], 2'b00}.
  - out_valid_o=0 the next cycle. The first new fetch issues the cycle after redirect and appears 2 cycles after that.
  - Back-to-back redirects: the last one wins.

Test Plan:
- Reset release, out_ready_i=1, imem returns word = addr: out_pc_o = 0,4,8,... on consecutive cycles; first out_valid_o 2 cycles after reset drops; instr == pc.
- Backpressure: out_ready_i=0 for 5 cycles at pc=8 -> out_pc_o holds 8 stable; exactly FIFO_DEPTH words buffered, imem_en_o=0; on release, 8,12,... with no loss or duplication.
- End of program: run to PC_LIMIT=88 -> last delivered pc=84, no request with addr >= 88, fetch_done_o=1 after the FIFO empties.
- Redirect at pc=20 to redirect_pc_i=0x43 -> in-flight/buffered words dropped; next delivered pc=0x40, then 0x44.
- Redirect coinciding with a handshake of pc=12 -> pc=12 counted as transferred once; next valid pc is the redirect target.
- Synchronous reset asserted mid-stream with FIFO full -> next cycle out_valid_o=0, fetch_done_o=0; restart from RESET_PC with the stale response discarded.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect, and the
// {instr, pc} valid/ready output channel. master = fetch stage, slave = its environment.
interface instr_fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              imem_en_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_instr_o;
  logic [ADDR_W-1:0] out_pc_o;
  logic              fetch_done_o;

  modport master (
    output imem_en_o,
    output imem_addr_o,
    input  imem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output out_valid_o,
    input  out_ready_i,
    output out_instr_o,
    output out_pc_o,
    output fetch_done_o
  );

  modport slave (
    input  imem_en_o,
    input  imem_addr_o,
    output imem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_instr_o,
    input  out_pc_o,
    input  fetch_done_o
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch front-end: issues word-aligned reads to a 1-cycle synchronous
// imem, buffers {pc, instr} in a small FIFO, supports redirect/flush and a PC limit.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_FETCH | issuing reads while fetch_pc < PC_LIMIT and FIFO credit allows
// S_DRAIN | limit reached; waiting for FIFO and in-flight read to empty
// S_DONE  | all fetched words delivered; fetch_done_o=1 until redirect/reset
module instr_fetch_stage #(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] PC_LIMIT   = ADDR_W'(88)
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_stage_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [ADDR_W-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]       r_fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_below_limit;
  logic [CNT_W:0]    w_occupancy;
  logic              w_credit_ok;
  logic              w_issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_empty       = (r_count == '0);
  assign w_pop         = !w_empty && bus.out_ready_i;
  assign w_push        = r_inflight && !bus.redirect_i;
  assign w_below_limit = (r_fetch_pc < PC_LIMIT);

  // Credit counts the in-flight read so its response always finds a free slot.
  assign w_occupancy = {1'b0, r_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
  assign w_credit_ok = (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  assign w_issue = (r_state == S_FETCH) && !reset && !bus.redirect_i &&
                   w_below_limit && w_credit_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (bus.redirect_i) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);

      case (r_state)
        S_FETCH: if (!w_below_limit) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty && !r_inflight) r_state <= S_DONE;
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Payload storage needs no reset: out_* are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
      r_fifo_instr[r_wr_ptr] <= bus.imem_rdata_i;
    end
  end

  assign bus.imem_en_o    = w_issue;
  assign bus.imem_addr_o  = r_fetch_pc;
  assign bus.out_valid_o  = !w_empty;
  assign bus.out_instr_o  = w_empty ? 32'd0 : r_fifo_instr[r_rd_ptr];
  assign bus.out_pc_o     = w_empty ? '0 : r_fifo_pc[r_rd_ptr];
  assign bus.fetch_done_o = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, hand-written
// redirect/reset sequences, and a randomized run against a delivery-order model.
module tb_instr_fetch_stage;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RPC    = 32'd0;
  localparam logic [31:0] LIMIT  = 32'd88;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_stage_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_stage #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC), .PC_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic scramble = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? (a ^ 32'hC0DE_0000) : a;
  endfunction

  // Synchronous instruction memory with 1-cycle latency; garbage when not read.
  always @(posedge clk)
    bus.imem_rdata_i <= bus.imem_en_o ? mem_word(bus.imem_addr_o) : $urandom();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    reset             = rst;
    bus.out_ready_i   = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("rst_en", 32'(bus.imem_en_o), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc,
                     input logic een, input logic [31:0] eaddr, input logic edone);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.e_valid = ev; v.e_pc = epc;
    v.e_en = een; v.e_addr = eaddr; v.e_done = edone;
    tbl.push_back(v);
  endtask

  // Random-run model state
  logic [31:0] exp_next, issue_pc, prev_pc, prev_instr;
  int          outstanding, stuck, n12;
  logic        prev_valid, prev_ready, prev_flush, after_reset;

  initial begin
    reset = 1'b1;
    bus.out_ready_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;

    // ---------------- table: stream, backpressure, redirect, end of program
    add(1,0,0,    0,0,     1,0,    0);
    add(1,0,0,    0,0,     1,4,    0);
    add(1,0,0,    1,0,     1,8,    0);
    add(1,0,0,    1,4,     1,12,   0);
    add(0,0,0,    1,8,     0,0,    0);
    add(0,0,0,    1,8,     0,0,    0);
    add(0,0,0,    1,8,     0,0,    0);
    add(0,0,0,    1,8,     0,0,    0);
    add(0,0,0,    1,8,     0,0,    0);
    add(1,0,0,    1,8,     1,16,   0);
    add(1,0,0,    1,12,    1,20,   0);
    add(1,0,0,    1,16,    1,24,   0);
    add(1,1,'h43, 1,20,    0,0,    0);
    add(1,0,0,    0,0,     1,'h40, 0);
    add(1,0,0,    0,0,     1,'h44, 0);
    add(1,0,0,    1,'h40,  1,'h48, 0);
    add(1,0,0,    1,'h44,  1,'h4C, 0);
    add(1,0,0,    1,'h48,  1,'h50, 0);
    add(1,0,0,    1,'h4C,  1,'h54, 0);
    add(1,0,0,    1,'h50,  0,0,    0);
    add(1,0,0,    1,'h54,  0,0,    0);
    add(1,0,0,    0,0,     0,0,    0);
    add(1,0,0,    0,0,     0,0,    1);
    add(0,0,0,    0,0,     0,0,    1);

    do_reset();
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_done",  32'(bus.fetch_done_o), 32'd0);
    check("rst_pc",    bus.out_pc_o, 32'd0);
    foreach (tbl[i]) begin
      cyc(1'b0, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      check($sformatf("t%0d_valid", i), 32'(bus.out_valid_o), 32'(tbl[i].e_valid));
      check($sformatf("t%0d_pc", i),    bus.out_pc_o, tbl[i].e_pc);
      check($sformatf("t%0d_instr", i), bus.out_instr_o, tbl[i].e_pc);
      check($sformatf("t%0d_en", i),    32'(bus.imem_en_o), 32'(tbl[i].e_en));
      if (tbl[i].e_en) check($sformatf("t%0d_addr", i), bus.imem_addr_o, tbl[i].e_addr);
      check($sformatf("t%0d_done", i),  32'(bus.fetch_done_o), 32'(tbl[i].e_done));
    end

    // ---------------- redirect coinciding with handshake of pc=12, then back-to-back
    do_reset();
    n12 = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 1'b1, (c == 5), 32'h30);
      if (bus.out_valid_o && bus.out_pc_o == 32'd12) n12++;
      if (c == 5) begin
        check("hs12_pc", bus.out_pc_o, 32'd12);
        check("hs12_en", 32'(bus.imem_en_o), 32'd0);
      end
      if (c == 6) check("hs12_flush", 32'(bus.out_valid_o), 32'd0);
      if (c == 6) check("hs12_addr", bus.imem_addr_o, 32'h30);
      if (c == 8) check("hs12_tgt0", bus.out_pc_o, 32'h30);
      if (c == 9) check("hs12_tgt1", bus.out_pc_o, 32'h34);
    end
    check("hs12_once", 32'(n12), 32'd1);
    cyc(1'b0, 1'b1, 1'b1, 32'h10);
    cyc(1'b0, 1'b1, 1'b1, 32'h21);
    check("b2b_en", 32'(bus.imem_en_o), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("b2b_valid", 32'(bus.out_valid_o), 32'd0);
    check("b2b_addr", bus.imem_addr_o, 32'h20);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("b2b_pc", bus.out_pc_o, 32'h20);

    // ---------------- reset with FIFO full
    do_reset();
    for (int c = 0; c < 7; c++) cyc(1'b0, (c < 4), 1'b0, 32'd0);
    check("full_en", 32'(bus.imem_en_o), 32'd0);
    check("full_pc", bus.out_pc_o, 32'd8);
    cyc(1'b1, 1'b0, 1'b0, 32'd0);
    check("full_rst_en", 32'(bus.imem_en_o), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("full_post_valid", 32'(bus.out_valid_o), 32'd0);
    check("full_post_done",  32'(bus.fetch_done_o), 32'd0);
    check("full_post_addr",  bus.imem_addr_o, RPC);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("full_restart_pc", bus.out_pc_o, RPC);

    // ---------------- reset with a read in flight: stale response must not appear
    do_reset();
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("stale_v0", 32'(bus.out_valid_o), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("stale_v1", 32'(bus.out_valid_o), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("stale_pc0", bus.out_pc_o, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    check("stale_pc1", bus.out_pc_o, 32'd4);

    // ---------------- randomized run against the delivery-order model
    scramble = 1'b1;
    do_reset();
    exp_next = RPC; issue_pc = RPC; outstanding = 0; stuck = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_flush = 1'b0; prev_pc = '0; prev_instr = '0;
    after_reset = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic        rst, rdy, redir, hs;
      logic [31:0] rpc;
      rst   = ($urandom_range(0, 199) == 0);
      redir = !rst && ($urandom_range(0, 39) == 0);
      rdy   = ($urandom_range(0, 99) < 70);
      rpc   = $urandom_range(0, 130);
      cyc(rst, rdy, redir, rpc);
      if (rst) begin
        check("r_rst_en", 32'(bus.imem_en_o), 32'd0);
        exp_next = RPC; issue_pc = RPC; outstanding = 0; stuck = 0;
        prev_valid = 1'b0; after_reset = 1'b1;
        continue;
      end
      if (after_reset) begin
        check("r_post_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check("r_post_rst_done",  32'(bus.fetch_done_o), 32'd0);
        after_reset = 1'b0;
      end
      if (!bus.out_valid_o) begin
        check("r_empty_pc",    bus.out_pc_o, 32'd0);
        check("r_empty_instr", bus.out_instr_o, 32'd0);
      end
      if (prev_valid && !prev_ready && !prev_flush) begin
        check("r_hold_valid", 32'(bus.out_valid_o), 32'd1);
        check("r_hold_pc",    bus.out_pc_o, prev_pc);
        check("r_hold_instr", bus.out_instr_o, prev_instr);
      end
      hs = bus.out_valid_o && rdy;
      if (hs) begin
        check("r_pc",    bus.out_pc_o, exp_next);
        check("r_instr", bus.out_instr_o, mem_word(exp_next));
        exp_next = exp_next + 32'd4;
        outstanding--;
      end
      if (redir) begin
        check("r_redir_en", 32'(bus.imem_en_o), 32'd0);
      end else if (bus.imem_en_o) begin
        check("r_addr",   bus.imem_addr_o, issue_pc);
        check("r_limit",  32'(bus.imem_addr_o < LIMIT), 32'd1);
        check("r_credit", 32'(outstanding < DEPTH), 32'd1);
        issue_pc = issue_pc + 32'd4;
        outstanding++;
      end
      if (bus.fetch_done_o)
        check("r_done_ok", 32'(exp_next >= LIMIT && outstanding == 0 && !bus.out_valid_o), 32'd1);
      if (!bus.fetch_done_o && !bus.imem_en_o && !hs && !(bus.out_valid_o && !rdy) && !redir)
        stuck++;
      else
        stuck = 0;
      check("r_progress", 32'(stuck <= 6), 32'd1);
      if (stuck > 6) stuck = 0;
      if (redir) begin
        exp_next = {rpc[31:2], 2'b00};
        issue_pc = exp_next;
        outstanding = 0;
      end
      prev_valid = bus.out_valid_o;
      prev_ready = rdy;
      prev_flush = redir;
      prev_pc    = bus.out_pc_o;
      prev_instr = bus.out_instr_o;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
